// File: rtl/result_uart_pkg.sv
// Shared types and defaults for the result UART transmitter.
//   tx_state_t           : serialiser FSM states
//   DEFAULT_*            : default parameter values for result_uart_tx
//   BYTES_PER_WORD       : bytes per result word at the default width
package result_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DEFAULT_DATA_W       = 40;
  localparam int unsigned DEFAULT_DEPTH        = 16;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int unsigned BYTES_PER_WORD       = DEFAULT_DATA_W / 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and registered status flags.
//   clk, rst    : clock, async active-low reset (contents are lost)
//   push_i      : write wr_data_i (accepted if not full, or if popping too)
//   wr_data_i   : write data
//   pop_i       : read head into rd_data_o (ignored when empty)
//   rd_data_o   : head word captured on the accepted pop edge
//   full_o      : occupancy == DEPTH
//   empty_o     : occupancy == 0
//   level_o     : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_q || pop_ok);

  // Next occupancy.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - LW'(1);
    end
  end

  // Pointers, occupancy, flags and read register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == LW'(DEPTH));
      empty_q <= (count_d == '0);
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage array; no reset needed since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = count_q;

endmodule

// File: rtl/result_uart_tx.sv
// Buffers processor result words and sends each as DATA_W/8 UART 8N1 bytes,
// least-significant byte first.
//   clk, rst    : clock, async active-low reset (aborts any frame, tx -> 1)
//   data_in     : result word, sampled while data_valid is high
//   data_valid  : processor enable
//   tx          : serial line, idles high
//   busy        : a word is being serialised
//   overflow    : sticky, a word was dropped on a full FIFO
//   level       : FIFO occupancy
module result_uart_tx
  import result_uart_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   data_valid,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  tx_state_t         state_q;
  logic              tx_q, busy_q, ovf_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        bit_idx_q;
  logic [BW-1:0]     byte_idx_q;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [7:0]        cur_byte;
  logic              bit_done;

  // The FSM takes a word whenever it is idle and one is waiting.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign cur_byte = shreg_q[7:0];
  assign bit_done = (cnt_q == CW'(CLKS_PER_BIT - 1));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (data_valid),
    .wr_data_i (data_in),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  // Serialiser FSM, shift register and bit-time counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
    end else begin
      if (data_valid && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          cnt_q      <= '0;
          bit_idx_q  <= '0;
          byte_idx_q <= '0;
          if (!fifo_empty) begin
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end else begin
            tx_q <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            // The popped word lands in the FIFO read register one edge after
            // the pop, so the first byte is picked up here rather than in IDLE.
            if (byte_idx_q == '0) begin
              shreg_q <= fifo_rd_data;
              tx_q    <= fifo_rd_data[0];
            end else begin
              tx_q <= cur_byte[0];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (byte_idx_q < BW'(NBYTES - 1)) begin
              shreg_q    <= shreg_q >> 8;
              byte_idx_q <= byte_idx_q + BW'(1);
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Consumes the 40-bit result words the processor presents on `data` while `enable` is high, buffers them in a small FIFO and transmits each word over a UART 8N1 line as five bytes, least-significant byte first. It sits directly downstream of the processor output port. It replaces simulation file dumping with a physical serial link to a host.

## Interface
Parameters:
- `DATA_W`, 40, width of one result word; must be a multiple of 8.
- `DEPTH`, 16, number of FIFO entries; power of two, at least 2.
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); at least 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `data_in`  in  `DATA_W`  result word from the processor `data` output.
- `data_valid`  in  1  processor `enable`; `data_in` is sampled on each rising edge where this is high.
- `tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  high while a word is being serialised (FSM not in IDLE).
- `overflow`  out  1  sticky; set when a word is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: on a rising edge with `data_valid`=1, the FIFO writes `data_in` if it is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the word is discarded and `overflow` is set to 1.
  - `overflow` stays set until reset.
- Simultaneous push and pop while full: the push is accepted and `level` is unchanged.
- Simultaneous push and pop while empty: not possible, because a pop requires `level`>0 before the edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `level`>0, pop the head word into a `DATA_W` shift register, clear the byte counter, drive `tx`<=0 and go to START. Otherwise `tx`<=1.
  - START: hold `tx`=0 for `CLKS_PER_BIT` cycles, then load bit 0 of the current byte and go to DATA.
  - DATA: send bits 0..7 of byte `shreg[7:0]`, LSB first, each held `CLKS_PER_BIT` cycles. After bit 7 drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. Then:
    - if the byte counter is less than `DATA_W`/8-1: shift the register right by 8, increment the counter, drive `tx`<=0 and go to START;
    - otherwise go to IDLE.
- Byte order: byte k = `data_in[8k+7:8k]`, sent for k = 0..`DATA_W`/8-1.
- Counters: a bit-time counter runs 0..`CLKS_PER_BIT`-1 and wraps; a bit index runs 0..7.
- Reset mid-frame: aborts the frame immediately, `tx` returns to 1 asynchronously, and FIFO contents are lost.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `level`=0, FSM in IDLE, all counters 0.
- Latency, word pushed into an empty FIFO while idle:
  - edge N: `level` becomes 1;
  - edge N+1: pop, `level` returns to 0, `tx` falls, `busy` rises.
- Each byte frame is exactly 10×`CLKS_PER_BIT` cycles.
- Bytes within a word are sent back-to-back with no gap.
- Word duration: 10×(`DATA_W`/8)×`CLKS_PER_BIT` cycles from the `tx` fall to the end of the last stop bit.
- Between consecutive words, IDLE adds exactly one cycle of extra stop time (`tx`=1).
- `busy` falls on the edge that enters IDLE.
- Sustained throughput is one word per 50×`CLKS_PER_BIT`+1 cycles. Bursts longer than `DEPTH` words at a higher rate overflow.

## Structure
- Package `result_uart_pkg`:
  - state enum `tx_state_t` {IDLE, START, DATA, STOP};
  - constant `BYTES_PER_WORD` = `DATA_W`/8;
  - default constants for `CLKS_PER_BIT`.
- Sub-module `sync_fifo`, parameterised on width and depth:
  - push/pop/full/empty/level;
  - read data registered at pop;
  - async active-low reset.
- The top level contains the FSM, the shift register and the bit-time counter only.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DEPTH`=4.
- Reset: assert `rst`=0 mid-frame -> `tx`=1, `busy`=0, `level`=0 immediately; no further transitions on `tx`.
- Single word: one-cycle `data_valid` with `data_in`=40'h0102030405 -> `tx` falls 1 cycle later. Bench UART decoder receives bytes 05,04,03,02,01, each frame 40 cycles, total 200 cycles, then `busy`=0.
- Back-to-back: two words pushed on consecutive cycles (40'hAA..., 40'h55...) -> `level` peaks at 1. The second word's start bit begins exactly 1 cycle after the first word's final stop bit.
- Overflow: push 6 words on consecutive cycles into an empty FIFO -> 1 popped, 4 stored, the 6th dropped. `overflow`=1 and stays 1; exactly 5 words are received.
- Push and pop while full: fill the FIFO, then push on the IDLE pop cycle -> `level` stays 4, `overflow` stays 0.
- Bit timing: every `tx` level lasts a multiple of 4 cycles within a frame. The start bit is low and the stop bit is high for every byte.
